multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style main control FSM for the multicycle RV32I core: sequences a single shared ALU, the unified instruction/data memory port and the register-file write port across fetch, decode, execute, memory and writeback cycles. It consumes the opcode/funct3 of the latched instruction register and the ALU `zero` flag. It drives `alu_op` into the existing ALU decoder (00 = ADD, 01 = SUB, 10 = funct-decoded) plus all datapath mux selects and write strobes.

## Interface
- No parameters.
- `clk`  in  1  core clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `opcode`  in  7  from instruction register; stable from DECODE until the next FETCH.
- `funct3`  in  3  from instruction register.
- `zero`  in  1  ALU zero flag, combinational from the current ALU operands.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `alu_op`  out  2  to ALU decoder.
- `src_a`  out  2  ALU A: 00 PC, 01 old PC, 10 rs1.
- `src_b`  out  2  ALU B: 00 rs2, 01 immediate, 10 constant 4.
- `result_src`  out  2  result bus: 00 ALUOut register, 01 memory data register, 10 ALU result.
- `adr_src`  out  1  memory address: 0 PC, 1 result bus.
- `mem_req`, `mem_write`, `ir_write`, `pc_write`, `reg_write`  out  1 each  strobes.
- `illegal`  out  1  one-cycle pulse on unsupported instruction.
- `instr_done`  out  1  one-cycle pulse in the final cycle of each retired instruction.
- `state`  out  4  current state encoding (debug).

## Operation
- States/encodings: RESET 0, FETCH 1, DECODE 2, MEM_ADR 3, MEM_READ 4, MEM_WB 5, MEM_WRITE 6, EXEC_R 7, EXEC_I 8, ALU_WB 9, JAL 10, BRANCH 11, ILLEGAL 12. Codes 13–15 behave as RESET (all outputs 0, next FETCH).
- All outputs are combinational from `state`, except where qualified below. Any signal not listed for a state is 0.
- RESET: everything 0 → FETCH.
- FETCH: `mem_req`, `adr_src`=0, `src_a`=00, `src_b`=10, `alu_op`=00, `result_src`=10. `ir_write` and `pc_write` are asserted only when the access completes. Exit → DECODE on completion.
- DECODE: `src_a`=01, `src_b`=01, `alu_op`=00 (branch target into ALUOut). Next state by opcode:
  - 0000011/0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1101111 → JAL
  - 1100011 with funct3 000/001 → BRANCH
  - anything else → ILLEGAL
- MEM_ADR: `src_a`=10, `src_b`=01, `alu_op`=00. Next: MEM_READ if opcode 0000011, else MEM_WRITE.
- MEM_READ: `mem_req`, `adr_src`=1, `result_src`=00. Next: MEM_WB on completion.
- MEM_WB: `result_src`=01, `reg_write`, `instr_done`. Next: FETCH.
- MEM_WRITE: `mem_req`, `mem_write`, `adr_src`=1, `result_src`=00. `instr_done` on completion. Next: FETCH on completion.
- EXEC_R: `src_a`=10, `src_b`=00, `alu_op`=10. Next: ALU_WB.
- EXEC_I: `src_a`=10, `src_b`=01, `alu_op`=10. Next: ALU_WB.
- ALU_WB: `result_src`=00, `reg_write`, `instr_done`. Next: FETCH.
- JAL: `src_a`=01, `src_b`=10, `alu_op`=00, `result_src`=00, `pc_write`. PC ← target; ALUOut ← old PC+4. Next: ALU_WB.
- BRANCH: `src_a`=10, `src_b`=00, `alu_op`=01, `result_src`=00, `pc_write` = `zero` XOR `funct3[0]` (BEQ/BNE), `instr_done`. Next: FETCH.
- ILLEGAL: `illegal`=1, no strobes, no `instr_done`. Next: FETCH. PC has already advanced by 4.

## Timing
- "Completion" means `mem_ready`=1 in that cycle (see Configuration).
- Zero-wait cycle counts:
  - load 5
  - store 4
  - R-type 4
  - I-type 4
  - JAL 4
  - branch 3
  - illegal 3
- Each wait cycle in FETCH, MEM_READ or MEM_WRITE adds one cycle. While waiting, outputs hold and `ir_write`/`pc_write`/`instr_done` stay 0.
- `rst_n` low at any time forces RESET immediately, all outputs 0, including mid-access. The first rising edge with `rst_n` high enters FETCH.
- `opcode`, `funct3` and `zero` are sampled only in the states listed above; changes elsewhere have no effect.
- `pc_write` and `reg_write` are never both asserted with `mem_write` in the same cycle.

## Configuration
- `MC_CTRL_MEM_WAIT_EN` defined: completion requires `mem_ready`=1, and FETCH, MEM_READ and MEM_WRITE stall until it.
- Undefined: `mem_ready` is ignored. Every memory state completes in one cycle, giving the zero-wait cycle counts.

## Test plan
- Reset: assert `rst_n`=0 mid-MEM_READ → same cycle `state`=0, all outputs 0. Release → FETCH next edge with `mem_req`=1.
- R-type: opcode 0110011, `mem_ready`=1 → `state` sequence 1,2,7,9,1. `alu_op`=10 in EXEC_R, `reg_write`=1 only in ALU_WB, `instr_done` once.
- Load with 2 wait cycles (macro defined): opcode 0000011, `mem_ready` low 2 cycles in MEM_READ → 7 cycles total, `result_src`=01 with `reg_write` in MEM_WB.
- Branch: BEQ with `zero`=1 → `pc_write`=1 in BRANCH. BNE with `zero`=1 → `pc_write`=0. `alu_op`=01 in both.
- JAL: opcode 1101111 → `state` sequence 1,2,10,9,1. `pc_write` in FETCH and JAL, `reg_write` in ALU_WB.
- Illegal: opcode 0000000 → `state` sequence 1,2,12,1. `illegal` pulses for 1 cycle, no `reg_write`/`mem_write`, no `instr_done`.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I core.
// Define MC_CTRL_MEM_WAIT_EN to make the memory states stall on mem_ready.
module multicycle_control (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] alu_op,
    output logic [1:0] src_a,
    output logic [1:0] src_b,
    output logic [1:0] result_src,
    output logic       adr_src,
    output logic       mem_req,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic       illegal,
    output logic       instr_done,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADR   = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXEC_R    = 4'd7,
        S_EXEC_I    = 4'd8,
        S_ALU_WB    = 4'd9,
        S_JAL       = 4'd10,
        S_BRANCH    = 4'd11,
        S_ILLEGAL   = 4'd12
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    state_t state_d;
    state_t dec_next;
    logic   mem_done;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_done = mem_ready;
`else
    // Memory always answers in one cycle; mem_ready is deliberately ignored.
    assign mem_done = 1'b1 | mem_ready;
`endif

    assign state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    // Only BEQ/BNE are implemented among the branches.
    always_comb begin
        dec_next = S_ILLEGAL;
        unique case (1'b1)
            opcode == OP_LOAD,
            opcode == OP_STORE: dec_next = S_MEM_ADR;
            opcode == OP_R:     dec_next = S_EXEC_R;
            opcode == OP_I:     dec_next = S_EXEC_I;
            opcode == OP_JAL:   dec_next = S_JAL;
            opcode == OP_BRANCH && funct3[2:1] == 2'b00:
                                dec_next = S_BRANCH;
            default:            dec_next = S_ILLEGAL;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        alu_op     = 2'b00;
        src_a      = 2'b00;
        src_b      = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                src_b      = 2'b10;
                result_src = 2'b10;
                ir_write   = mem_done;
                pc_write   = mem_done;
                if (mem_done) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_a   = 2'b01;
                src_b   = 2'b01;
                state_d = dec_next;
            end
            S_MEM_ADR: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                mem_req    = 1'b1;
                mem_write  = 1'b1;
                adr_src    = 1'b1;
                instr_done = mem_done;
                if (mem_done) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                src_a   = 2'b10;
                alu_op  = 2'b10;
                state_d = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a   = 2'b10;
                src_b   = 2'b01;
                alu_op  = 2'b10;
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JAL: begin
                src_a    = 2'b01;
                src_b    = 2'b10;
                pc_write = 1'b1;
                state_d  = S_ALU_WB;
            end
            S_BRANCH: begin
                src_a      = 2'b10;
                alu_op     = 2'b01;
                pc_write   = zero ^ funct3[0];
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against a per-instruction model.
// Honours MC_CTRL_MEM_WAIT_EN to choose between stalling and zero-wait memory.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       mem_ready;
    logic [1:0] alu_op, src_a, src_b, result_src;
    logic       adr_src, mem_req, mem_write, ir_write;
    logic       pc_write, reg_write, illegal, instr_done;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

`ifdef MC_CTRL_MEM_WAIT_EN
    localparam bit WAIT_MODE = 1'b1;
`else
    localparam bit WAIT_MODE = 1'b0;
`endif

    localparam int K_LOAD = 0, K_STORE = 1, K_R = 2, K_I = 3;
    localparam int K_JAL = 4, K_BEQ = 5, K_BNE = 6, K_ILL = 7;

    typedef struct packed {
        logic [3:0] st;
        logic       mr;
    } ent_t;

    multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
        .zero(zero), .mem_ready(mem_ready), .alu_op(alu_op),
        .src_a(src_a), .src_b(src_b), .result_src(result_src),
        .adr_src(adr_src), .mem_req(mem_req), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .illegal(illegal), .instr_done(instr_done), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ctl_now();
        return {alu_op, src_a, src_b, result_src, adr_src, mem_req,
                mem_write, ir_write, pc_write, reg_write, illegal, instr_done};
    endfunction

    // Control word each state must present, straight from the state table.
    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr,
                                            input logic z, input logic [2:0] f3);
        logic [1:0] a, sa, sb, rs;
        logic ad, mq, mw, iw, pw, rw, il, dn, fin;
        {a, sa, sb, rs} = '0;
        {ad, mq, mw, iw, pw, rw, il, dn} = '0;
        fin = WAIT_MODE ? mr : 1'b1;
        case (st)
            4'd1:  begin mq = 1; sb = 2'b10; rs = 2'b10; iw = fin; pw = fin; end
            4'd2:  begin sa = 2'b01; sb = 2'b01; end
            4'd3:  begin sa = 2'b10; sb = 2'b01; end
            4'd4:  begin mq = 1; ad = 1; end
            4'd5:  begin rs = 2'b01; rw = 1; dn = 1; end
            4'd6:  begin mq = 1; mw = 1; ad = 1; dn = fin; end
            4'd7:  begin sa = 2'b10; a = 2'b10; end
            4'd8:  begin sa = 2'b10; sb = 2'b01; a = 2'b10; end
            4'd9:  begin rw = 1; dn = 1; end
            4'd10: begin sa = 2'b01; sb = 2'b10; pw = 1; end
            4'd11: begin sa = 2'b10; a = 2'b01; pw = z ^ f3[0]; dn = 1; end
            4'd12: il = 1;
            default: ;
        endcase
        return {a, sa, sb, rs, ad, mq, mw, iw, pw, rw, il, dn};
    endfunction

    function automatic bit legal_op(input logic [6:0] op);
        return op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
               op == 7'b0010011 || op == 7'b1101111 || op == 7'b1100011;
    endfunction

    task automatic pick_enc(input int kind, output logic [6:0] op,
                            output logic [2:0] f3);
        f3 = 3'($urandom);
        case (kind)
            K_LOAD:  op = 7'b0000011;
            K_STORE: op = 7'b0100011;
            K_R:     op = 7'b0110011;
            K_I:     op = 7'b0010011;
            K_JAL:   op = 7'b1101111;
            K_BEQ:   begin op = 7'b1100011; f3 = 3'b000; end
            K_BNE:   begin op = 7'b1100011; f3 = 3'b001; end
            default: begin
                if ($urandom_range(0, 1) == 0) begin
                    op = 7'b1100011;
                    f3 = 3'($urandom_range(2, 7));
                end else begin
                    op = 7'($urandom);
                    while (legal_op(op)) op = 7'($urandom);
                end
            end
        endcase
    endtask

    task automatic push_state(inout ent_t q[$], input logic [3:0] st,
                              input int waits);
        ent_t e;
        for (int w = 0; w < waits; w++) begin
            e.st = st; e.mr = 1'b0; q.push_back(e);
        end
        e.st = st;
        e.mr = WAIT_MODE ? 1'b1 : 1'($urandom);
        q.push_back(e);
    endtask

    // Called 1 time unit after an edge with the DUT sitting in FETCH.
    task automatic run_instr(input int kind, input logic [6:0] op,
                             input logic [2:0] f3, input int wf_in,
                             input int wm_in, input int zmode);
        ent_t q[$];
        int   base[8] = '{5, 4, 4, 4, 4, 3, 3, 3};
        int   wf, wm, cyc, dones;
        bit   seen, ended;
        logic [3:0] es;
        wf = WAIT_MODE ? wf_in : 0;
        wm = WAIT_MODE ? wm_in : 0;
        push_state(q, 4'd1, wf);
        push_state(q, 4'd2, 0);
        case (kind)
            K_LOAD:  begin push_state(q, 4'd3, 0); push_state(q, 4'd4, wm);
                           push_state(q, 4'd5, 0); end
            K_STORE: begin push_state(q, 4'd3, 0); push_state(q, 4'd6, wm); end
            K_R:     begin push_state(q, 4'd7, 0); push_state(q, 4'd9, 0); end
            K_I:     begin push_state(q, 4'd8, 0); push_state(q, 4'd9, 0); end
            K_JAL:   begin push_state(q, 4'd10, 0); push_state(q, 4'd9, 0); end
            K_BEQ, K_BNE: push_state(q, 4'd11, 0);
            default: push_state(q, 4'd12, 0);
        endcase
        if (kind != K_LOAD && kind != K_STORE) wm = 0;
        cyc = 0; dones = 0; seen = 0; ended = 0;
        for (int i = 0; i < 24; i++) begin
            es = (i < q.size()) ? q[i].st : 4'd15;
            mem_ready = (i < q.size()) ? q[i].mr : 1'b1;
            zero = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            if (es == 4'd1) begin
                opcode = 7'($urandom); funct3 = 3'($urandom);
            end else begin
                opcode = op; funct3 = f3;
            end
            #1;
            check("state", 32'(state), 32'(es));
            check("ctl", 32'(ctl_now()), 32'(exp_ctl(es, mem_ready, zero, f3)));
            if (instr_done) dones++;
            if (state != 4'd1) seen = 1;
            @(posedge clk); #1;
            cyc = i + 1;
            if (seen && state == 4'd1) begin ended = 1; break; end
        end
        check("ended", 32'(ended), 32'd1);
        check("cycles", 32'(cyc), 32'(base[kind] + wf + wm));
        check("done_cnt", 32'(dones), (kind == K_ILL) ? 32'd0 : 32'd1);
    endtask

    initial begin
        logic [6:0] op;
        logic [2:0] f3;
        int kind;
        rst_n = 1'b0; opcode = '0; funct3 = '0; zero = 1'b0; mem_ready = 1'b0;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(ctl_now()), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_exit", 32'(state), 32'd1);

        // Reset asserted in the middle of a data read.
        opcode = 7'b0000011; funct3 = 3'b010; mem_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        check("mid_rd_state", 32'(state), 32'd4);
        rst_n = 1'b0; #1;
        check("async_state", 32'(state), 32'd0);
        check("async_ctl", 32'(ctl_now()), 32'd0);
        @(posedge clk); #1;
        check("hold_state", 32'(state), 32'd0);
        rst_n = 1'b1; mem_ready = 1'b1;
        @(posedge clk); #1;
        check("rel_state", 32'(state), 32'd1);
        check("rel_req", 32'(mem_req), 32'd1);

        // Directed scenarios.
        pick_enc(K_R, op, f3);     run_instr(K_R, op, f3, 0, 0, -1);
        pick_enc(K_LOAD, op, f3);  run_instr(K_LOAD, op, f3, 0, 2, -1);
        pick_enc(K_BEQ, op, f3);   run_instr(K_BEQ, op, f3, 0, 0, 1);
        pick_enc(K_BNE, op, f3);   run_instr(K_BNE, op, f3, 0, 0, 1);
        pick_enc(K_BEQ, op, f3);   run_instr(K_BEQ, op, f3, 0, 0, 0);
        pick_enc(K_JAL, op, f3);   run_instr(K_JAL, op, f3, 0, 0, -1);
        run_instr(K_ILL, 7'b0000000, 3'b000, 0, 0, -1);
        pick_enc(K_STORE, op, f3); run_instr(K_STORE, op, f3, 1, 2, -1);

        for (int n = 0; n < 150; n++) begin
            kind = $urandom_range(0, 7);
            pick_enc(kind, op, f3);
            run_instr(kind, op, f3, $urandom_range(0, 2),
                      $urandom_range(0, 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
